cache_rd_ctrl: RTL and testbench
================================

# cache_rd_ctrl

Parametrised direct-mapped read cache controller. It sits between the load path and main memory, and generalises the fixed 16-line, single-word cache top:
- configurable set count and line size;
- multi-word line refill over a request/valid memory handshake;
- per-address flush with tag check;
- saturating hit and miss counters.

## Interface
Parameters:
- ADDR_W, 32, address width in bits; byte addresses, bits [1:0] ignored
- DATA_W, 32, data word width
- SETS, 16, number of lines; power of two, at least 2
- WORDS, 4, words per line; power of two, at least 1
- Derived widths: IDX_W = log2(SETS); OFF_W = log2(WORDS), 0 allowed; TAG_W = ADDR_W - IDX_W - OFF_W - 2

Ports:
- iClk  in  1  clock, rising-edge
- iRst  in  1  reset, asynchronous, active-high
- iReq  in  1  read request, sampled only while oReady=1
- iAddress  in  ADDR_W  request byte address
- oReady  out  1  high in IDLE only
- oValid  out  1  one-cycle pulse; oData valid
- oData  out  DATA_W  read data
- oHit  out  1  qualifies oValid; 1 = served without refill
- iFlush  in  1  invalidate request, accepted in any state
- iFlushAddress  in  ADDR_W  address to invalidate
- oMemReq  out  1  refill word request
- oMemAddress  out  ADDR_W  refill word address, word-aligned
- iMemValid  in  1  memory returns iMemData for the current oMemAddress
- iMemData  in  DATA_W  refill data
- oHitCount  out  32  saturating hit counter
- oMissCount  out  32  saturating miss counter

## Operation
- Storage per line: valid bit, TAG_W tag, WORDS data words.
- Address split: tag = [ADDR_W-1 : IDX_W+OFF_W+2], index = [IDX_W+OFF_W+1 : OFF_W+2], word offset = [OFF_W+1 : 2].
- FSM states: IDLE, LOOKUP, REFILL, RESPOND.
- IDLE → LOOKUP on iReq=1. Address is captured into an internal request register.
- LOOKUP: hit = valid & (stored tag == request tag).
  - Hit → RESPOND with oHit=1; oHitCount +1.
  - Miss → REFILL; oMissCount +1; word counter cleared.
- REFILL:
  - oMemReq=1 and oMemAddress = {request tag, index, counter, 2'b00}, held stable until iMemValid=1.
  - Each iMemValid writes iMemData into word[counter] and increments the counter.
  - On the last word (counter = WORDS-1): tag is written, valid set to 1, next state RESPOND with oHit=0.
  - The requested word is captured when it arrives, including when it is the last word.
- RESPOND: oValid=1 for exactly one cycle, oData = requested word, then IDLE.
- Flush: at the edge where iFlush=1, the line at index(iFlushAddress) is invalidated only if its stored tag matches tag(iFlushAddress). Data words are untouched.
- Counters saturate at 32'hFFFF_FFFF; no wrap.

## Timing
- Reset values: state IDLE, all valid bits 0, oReady=1, oValid=0, oHit=0, oData=0, oMemReq=0, oMemAddress=0, both counters 0. Data and tag arrays are not reset.
- Hit latency: request accepted at edge E0; oValid high during the cycle after E1; oReady high again after E2. Peak throughput is one hit per 3 cycles.
- Miss latency: 3 + WORDS + (total iMemValid wait cycles) edges from acceptance to oValid.
- iMemValid is ignored outside REFILL.
- iReq is ignored while oReady=0. The requester must hold iAddress only for the acceptance edge.
- Flush and request in IDLE, same line, same edge: the flush applies first, so the subsequent LOOKUP misses.
- Flush during LOOKUP: the lookup uses the valid bit as it stood before that edge, so the current request may still hit. The invalidation lands at the same edge.
- Flush during REFILL to the line being refilled: the tag check is against the old tag, and a pending-invalidate flag is set if the flush index and tag equal the request's. On completion the requester still receives data, but the line is left invalid.
- Reset asserted mid-REFILL: the state machine aborts immediately (asynchronously) and oMemReq drops without waiting for an edge. Late iMemValid after reset is ignored.
- WORDS=1: REFILL lasts one handshake; offset field is zero width.

## Test plan
- Reset, read 0x0000_0040 with memory returning 0xA0..0xA3 and zero wait → oMemAddress sequence 0x40, 0x44, 0x48, 0x4C; oData=0xA0, oHit=0; oMissCount=1.
- Re-read 0x0000_0048 → oValid two edges after acceptance, oData=0xA2, oHit=1, oHitCount=1, oMemReq never asserted.
- Conflict: read 0x0000_0040, then 0x0000_0140 (same index, different tag), then 0x0000_0040 → three misses. Random iMemValid stalls of 0–5 cycles must not change data or address ordering.
- Flush tag check: line 0x40 cached; flush 0x0000_0140 → next read of 0x40 hits. Flush 0x0000_0044 → next read of 0x40 misses.
- Flush during REFILL of the same line → requester gets correct data with oHit=0; the immediate re-read misses.
- Assert iRst during the third refill word → oMemReq=0 within the same cycle, oReady=1, counters 0, and a previously cached line misses.

Source files
------------

// File: rtl/cache_rd_ctrl.sv
// Direct-mapped read cache controller with multi-word line refill,
// tag-checked per-address flush and saturating hit/miss counters.
module cache_rd_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SETS   = 16,
  parameter int WORDS  = 4
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iReq,
  input  logic [ADDR_W-1:0] iAddress,
  output logic              oReady,
  output logic              oValid,
  output logic [DATA_W-1:0] oData,
  output logic              oHit,
  input  logic              iFlush,
  input  logic [ADDR_W-1:0] iFlushAddress,
  output logic              oMemReq,
  output logic [ADDR_W-1:0] oMemAddress,
  input  logic              iMemValid,
  input  logic [DATA_W-1:0] iMemData,
  output logic [31:0]       oHitCount,
  output logic [31:0]       oMissCount
);

  localparam int IDX_W = $clog2(SETS);
  localparam int OFF_W = (WORDS > 1) ? $clog2(WORDS) : 0;
  // The word counter keeps at least one bit so single-word lines still have a legal vector.
  localparam int CNT_W = (OFF_W > 0) ? OFF_W : 1;
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    REFILL,
    RESPOND
  } stateT;

  stateT state;

  logic [SETS-1:0]   validArr;
  logic [TAG_W-1:0]  tagArr  [SETS];
  logic [DATA_W-1:0] dataArr [SETS][WORDS];

  logic [TAG_W-1:0] reqTag;
  logic [IDX_W-1:0] reqIdx;
  logic [CNT_W-1:0] reqOff;
  logic [CNT_W-1:0] cnt;
  logic             pendInv;

  logic [IDX_W-1:0] flushIdx;
  logic [TAG_W-1:0] flushTag;
  logic             flushOldMatch;
  logic             flushReqMatch;
  logic             lookupHit;
  logic             wordAccept;
  logic             lastWord;
  logic             unusedAddrBits;

  function automatic logic [TAG_W-1:0] tagOf(input logic [ADDR_W-1:0] a);
    return TAG_W'(a >> (IDX_W + OFF_W + 2));
  endfunction

  function automatic logic [IDX_W-1:0] idxOf(input logic [ADDR_W-1:0] a);
    return IDX_W'(a >> (OFF_W + 2));
  endfunction

  // With single-word lines the mask is zero, so the offset is always word 0.
  function automatic logic [CNT_W-1:0] offOf(input logic [ADDR_W-1:0] a);
    return CNT_W'(a >> 2) & LAST_WORD;
  endfunction

  function automatic logic [ADDR_W-1:0] lineAddr(input logic [TAG_W-1:0] t,
                                                 input logic [IDX_W-1:0] i,
                                                 input logic [CNT_W-1:0] w);
    return (ADDR_W'({t, i}) << (OFF_W + 2)) | (ADDR_W'(w & LAST_WORD) << 2);
  endfunction

  assign flushIdx      = idxOf(iFlushAddress);
  assign flushTag      = tagOf(iFlushAddress);
  // A flush hits whatever tag is stored right now, even mid-refill (the old tag).
  assign flushOldMatch = iFlush && (tagArr[flushIdx] == flushTag);
  // A flush naming the very line being refilled must leave it invalid afterwards.
  assign flushReqMatch = iFlush && (flushIdx == reqIdx) && (flushTag == reqTag);
  assign lookupHit     = validArr[reqIdx] && (tagArr[reqIdx] == reqTag);
  assign wordAccept    = (state == REFILL) && oMemReq && iMemValid;
  assign lastWord      = (cnt == LAST_WORD);
  assign unusedAddrBits = ^{iAddress[1:0], iFlushAddress[OFF_W+1:0]};

  // Control FSM: request capture, lookup, refill handshake, response and valid bits.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state       <= IDLE;
      validArr    <= '0;
      oReady      <= 1'b1;
      oValid      <= 1'b0;
      oHit        <= 1'b0;
      oData       <= '0;
      oMemReq     <= 1'b0;
      oMemAddress <= '0;
      oHitCount   <= '0;
      oMissCount  <= '0;
      reqTag      <= '0;
      reqIdx      <= '0;
      reqOff      <= '0;
      cnt         <= '0;
      pendInv     <= 1'b0;
    end else begin
      oValid <= 1'b0;
      if (flushOldMatch) begin
        validArr[flushIdx] <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (iReq) begin
            reqTag <= tagOf(iAddress);
            reqIdx <= idxOf(iAddress);
            reqOff <= offOf(iAddress);
            oReady <= 1'b0;
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (lookupHit) begin
            oData  <= dataArr[reqIdx][reqOff];
            oHit   <= 1'b1;
            oValid <= 1'b1;
            if (oHitCount != 32'hFFFF_FFFF) begin
              oHitCount <= oHitCount + 32'd1;
            end
            state <= RESPOND;
          end else begin
            if (oMissCount != 32'hFFFF_FFFF) begin
              oMissCount <= oMissCount + 32'd1;
            end
            cnt     <= '0;
            pendInv <= 1'b0;
            oHit    <= 1'b0;
            state   <= REFILL;
          end
        end
        REFILL: begin
          if (flushReqMatch) begin
            pendInv <= 1'b1;
          end
          if (!oMemReq) begin
            oMemReq     <= 1'b1;
            oMemAddress <= lineAddr(reqTag, reqIdx, cnt);
          end else if (iMemValid) begin
            if (cnt == reqOff) begin
              oData <= iMemData;
            end
            if (lastWord) begin
              oMemReq          <= 1'b0;
              validArr[reqIdx] <= ~(pendInv | flushReqMatch);
              oHit             <= 1'b0;
              oValid           <= 1'b1;
              state            <= RESPOND;
            end else begin
              cnt         <= cnt + 1'b1;
              oMemAddress <= lineAddr(reqTag, reqIdx, cnt + 1'b1);
            end
          end
        end
        RESPOND: begin
          oReady <= 1'b1;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Tag and data storage are written only by refill and are deliberately not reset.
  always_ff @(posedge iClk) begin
    if (wordAccept) begin
      dataArr[reqIdx][cnt] <= iMemData;
      if (lastWord) begin
        tagArr[reqIdx] <= reqTag;
      end
    end
  end

endmodule

// File: tb/tb_cache_rd_ctrl.sv
// Self-checking bench for cache_rd_ctrl: directed scenarios then random reads,
// flushes and memory stalls against an address-level reference model.
module tb_cache_rd_ctrl;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SETS   = 16;
  localparam int WORDS  = 4;
  localparam int LINE_BYTES = 4 * WORDS;

  logic              clk = 1'b0;
  logic              iRst;
  logic              iReq;
  logic [ADDR_W-1:0] iAddress;
  logic              oReady;
  logic              oValid;
  logic [DATA_W-1:0] oData;
  logic              oHit;
  logic              iFlush;
  logic [ADDR_W-1:0] iFlushAddress;
  logic              oMemReq;
  logic [ADDR_W-1:0] oMemAddress;
  logic              iMemValid;
  logic [DATA_W-1:0] iMemData;
  logic [31:0]       oHitCount;
  logic [31:0]       oMissCount;

  int compared = 0;
  int mismatched = 0;

  bit          modelValid [SETS];
  int unsigned modelTag   [SETS];
  int unsigned modelHits;
  int unsigned modelMisses;

  cache_rd_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETS(SETS), .WORDS(WORDS)
  ) dut (
    .iClk(clk), .iRst(iRst), .iReq(iReq), .iAddress(iAddress),
    .oReady(oReady), .oValid(oValid), .oData(oData), .oHit(oHit),
    .iFlush(iFlush), .iFlushAddress(iFlushAddress),
    .oMemReq(oMemReq), .oMemAddress(oMemAddress),
    .iMemValid(iMemValid), .iMemData(iMemData),
    .oHitCount(oHitCount), .oMissCount(oMissCount)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Hard stop in case the bench itself ever wedges.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic int unsigned idxOf(input logic [31:0] a);
    return (a / LINE_BYTES) % SETS;
  endfunction

  function automatic int unsigned tagOf(input logic [31:0] a);
    return a / (LINE_BYTES * SETS);
  endfunction

  // Main memory contents: every word holds a value derived from its own address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'h90 + (a >> 2);
  endfunction

  function automatic logic [31:0] poolAddr();
    logic [31:0] a;
    if ($urandom_range(0, 7) == 0) begin
      a = $urandom & 32'hFFFF_FFFC;
    end else begin
      a = $urandom_range(0, 2) * LINE_BYTES * SETS + $urandom_range(0, 3) * LINE_BYTES
          + $urandom_range(0, WORDS - 1) * 4;
    end
    return a;
  endfunction

  task automatic modelFlush(input logic [31:0] a);
    if (modelValid[idxOf(a)] && modelTag[idxOf(a)] == tagOf(a)) begin
      modelValid[idxOf(a)] = 1'b0;
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < SETS; i++) begin
      modelValid[i] = 1'b0;
      modelTag[i] = 0;
    end
    modelHits = 0;
    modelMisses = 0;
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "HitCount"}, oHitCount, modelHits);
    checkOutput({tag, "MissCount"}, oMissCount, modelMisses);
  endtask

  // Single idle-cycle flush.
  task automatic applyStimulus(input logic [31:0] fAddr);
    checkOutput("flushReady", oReady, 1'b1);
    iFlush = 1'b1;
    iFlushAddress = fAddr;
    iMemValid = 1'($urandom_range(0, 1));
    modelFlush(fAddr);
    @(negedge clk);
    iFlush = 1'b0;
    iMemValid = 1'b0;
  endtask

  // One read transaction. phase: 0 no flush, 1 flush with the request,
  // 2 flush during lookup, 3 flush during refill.
  task automatic doRead(input logic [31:0] addr, input int maxWait, input int phase,
                        input logic [31:0] fAddr);
    int unsigned ri = idxOf(addr);
    int unsigned rt = tagOf(addr);
    logic [31:0] lineBase = addr & ~32'(LINE_BYTES - 1);
    bit expHit;
    bit pend = 1'b0;
    bit flushDone = 1'b0;
    int edges = 0;
    int words = 0;
    int waits = 0;
    int waitLeft;
    int guard = 0;

    checkOutput("readyIdle", oReady, 1'b1);
    iReq = 1'b1;
    iAddress = addr;
    iMemValid = 1'($urandom_range(0, 1));
    iMemData = $urandom;
    if (phase == 1) begin
      iFlush = 1'b1;
      iFlushAddress = fAddr;
      modelFlush(fAddr);
    end
    expHit = modelValid[ri] && (modelTag[ri] == rt);
    @(negedge clk);
    edges = 1;
    iReq = 1'b0;
    iAddress = $urandom;
    iFlush = 1'b0;
    iFlushAddress = $urandom;
    waitLeft = $urandom_range(0, maxWait);

    while (!oValid && guard < 300) begin
      iFlush = 1'b0;
      iMemValid = 1'b0;
      iMemData = $urandom;
      if (phase == 2 && edges == 1) begin
        iFlush = 1'b1;
        iFlushAddress = fAddr;
        modelFlush(fAddr);
      end
      if (oMemReq) begin
        checkOutput("memAddr", oMemAddress, lineBase + 32'(4 * words));
        if (phase == 3 && !flushDone) begin
          flushDone = 1'b1;
          iFlush = 1'b1;
          iFlushAddress = fAddr;
          if (idxOf(fAddr) == ri) begin
            if (tagOf(fAddr) == rt) pend = 1'b1;
          end else begin
            modelFlush(fAddr);
          end
        end
        if (waitLeft == 0) begin
          iMemValid = 1'b1;
          iMemData = memWord(lineBase + 32'(4 * words));
          words++;
          waitLeft = $urandom_range(0, maxWait);
        end else begin
          waitLeft--;
          waits++;
        end
      end else if (edges == 1) begin
        iMemValid = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      edges++;
      guard++;
    end
    iMemValid = 1'b0;
    iFlush = 1'b0;

    checkOutput("validSeen", oValid, 1'b1);
    checkOutput("rdData", oData, memWord(addr & 32'hFFFF_FFFC));
    checkOutput("rdHit", oHit, expHit);
    checkOutput("latency", edges, expHit ? 2 : 3 + WORDS + waits);
    checkOutput("refillWords", words, expHit ? 0 : WORDS);

    if (expHit) begin
      if (modelHits != 32'hFFFF_FFFF) modelHits++;
    end else begin
      if (modelMisses != 32'hFFFF_FFFF) modelMisses++;
      modelTag[ri] = rt;
      modelValid[ri] = !pend;
    end

    @(negedge clk);
    checkOutput("validPulse", oValid, 1'b0);
    checkOutput("readyBack", oReady, 1'b1);
    checkCounters("rd");
  endtask

  // Reset in the middle of a refill of lineBase, on its third word.
  task automatic resetMidRefill(input logic [31:0] lineBase);
    int words = 0;
    int guard = 0;
    bit resetDone = 1'b0;
    iReq = 1'b1;
    iAddress = lineBase;
    @(negedge clk);
    iReq = 1'b0;
    while (!resetDone && guard < 100) begin
      iMemValid = 1'b0;
      if (oMemReq) begin
        checkOutput("rstMemAddr", oMemAddress, lineBase + 32'(4 * words));
        if (words == 2) begin
          iRst = 1'b1;
          #1;
          checkOutput("rstMemReqDrop", oMemReq, 1'b0);
          checkOutput("rstReady", oReady, 1'b1);
          checkOutput("rstValid", oValid, 1'b0);
          checkOutput("rstHitCount", oHitCount, 0);
          checkOutput("rstMissCount", oMissCount, 0);
          resetDone = 1'b1;
        end else begin
          iMemValid = 1'b1;
          iMemData = memWord(lineBase + 32'(4 * words));
          words++;
        end
      end
      if (!resetDone) begin
        @(negedge clk);
        guard++;
      end
    end
    checkOutput("rstReached", resetDone, 1'b1);
    iRst = 1'b1;
    iMemValid = 1'b1;
    iMemData = $urandom;
    @(negedge clk);
    iRst = 1'b0;
    iMemValid = 1'b1;
    modelReset();
    @(negedge clk);
    iMemValid = 1'b0;
    checkOutput("postRstMemReq", oMemReq, 1'b0);
    checkOutput("postRstReady", oReady, 1'b1);
    checkCounters("postRst");
  endtask

  // Directed scenarios followed by a randomized run.
  initial begin
    iRst = 1'b1;
    iReq = 1'b0;
    iAddress = '0;
    iFlush = 1'b0;
    iFlushAddress = '0;
    iMemValid = 1'b0;
    iMemData = '0;
    modelReset();
    repeat (2) @(negedge clk);
    iRst = 1'b0;
    @(negedge clk);

    checkOutput("resetReady", oReady, 1'b1);
    checkOutput("resetValid", oValid, 1'b0);
    checkOutput("resetHit", oHit, 1'b0);
    checkOutput("resetData", oData, 0);
    checkOutput("resetMemReq", oMemReq, 1'b0);
    checkOutput("resetMemAddr", oMemAddress, 0);
    checkCounters("reset");

    doRead(32'h0000_0040, 0, 0, 0);
    checkOutput("firstData", oData, 32'hA0);
    doRead(32'h0000_0048, 0, 0, 0);
    checkOutput("rereadData", oData, 32'hA2);

    doRead(32'h0000_0140, 5, 0, 0);
    doRead(32'h0000_0040, 5, 0, 0);

    applyStimulus(32'h0000_0140);
    doRead(32'h0000_0040, 0, 0, 0);
    applyStimulus(32'h0000_0044);
    doRead(32'h0000_0040, 0, 0, 0);

    applyStimulus(32'h0000_0040);
    doRead(32'h0000_0044, 2, 3, 32'h0000_004C);
    doRead(32'h0000_0040, 0, 0, 0);

    doRead(32'h0000_0140, 0, 1, 32'h0000_0144);
    doRead(32'h0000_0140, 0, 2, 32'h0000_0148);
    doRead(32'h0000_0140, 0, 0, 0);

    resetMidRefill(32'h0000_0280);
    doRead(32'h0000_0040, 1, 0, 0);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        applyStimulus(poolAddr());
      end
      doRead(poolAddr(), $urandom_range(0, 5), $urandom_range(0, 3), poolAddr());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
